// File: rtl/dff8a_if.sv
// Signal bundle for the dff8a mux-flop: select, load data, recirculate data
// and the registered output.
interface dff8a_if;
  logic L;
  logic r_in;
  logic q_in;
  logic Q;

  modport master (output L, output r_in, output q_in, input Q);
  modport slave  (input L, input r_in, input q_in, output Q);
endinterface

// File: rtl/dff8a.sv
// Single D flip-flop fed by a 2:1 mux (L ? r_in : q_in), async active-high reset.
// Hold is done externally by looping Q back onto q_in with L=0.
module dff8a #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  dff8a_if.slave  bus
);

  logic next_q;
  logic q_r;

  always_comb begin
    next_q = bus.L ? bus.r_in : bus.q_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_r <= RESET_VALUE;
    else     q_r <= next_q;
  end

  assign bus.Q = q_r;

endmodule

// File: tb/tb_dff8a.sv
// Directed bench for dff8a: stimulus pushes expected Q values (for a default
// and a RESET_VALUE=1 instance) into a scoreboard; a monitor pops and compares.
module tb_dff8a;

  logic clk;
  logic rst;
  logic L;
  logic r_in;
  logic q_in;

  dff8a_if bus0 ();
  dff8a_if bus1 ();

  assign bus0.L    = L;
  assign bus0.r_in = r_in;
  assign bus0.q_in = q_in;
  assign bus1.L    = L;
  assign bus1.r_in = r_in;
  assign bus1.q_in = q_in;

  dff8a dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dff8a #(.RESET_VALUE(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  e0;
    logic  e1;
  } sb_entry_t;

  sb_entry_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Queue an expectation; the monitor samples 1 time unit later.
  task automatic expect_q(input string name, input logic e0, input logic e1);
    sb_entry_t e;
    e.name = name;
    e.e0   = e0;
    e.e1   = e1;
    sb.push_back(e);
    #2;
  endtask

  // Apply inputs mid-low-phase, then expect both instances at the next edge.
  task automatic cycle(input logic l_v, input logic r_v, input logic q_v,
                       input logic ex, input string name);
    @(negedge clk);
    L = l_v; r_in = r_v; q_in = q_v;
    @(posedge clk);
    expect_q(name, ex, ex);
  endtask

  initial begin : monitor
    sb_entry_t e;
    forever begin
      wait (sb.size() != 0);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (bus0.Q !== e.e0) begin
        n_errors++;
        $display("FAIL %s dut0: Q=%b expected %b at %0t", e.name, bus0.Q, e.e0, $time);
      end
      n_checks++;
      if (bus1.Q !== e.e1) begin
        n_errors++;
        $display("FAIL %s dut1: Q=%b expected %b at %0t", e.name, bus1.Q, e.e1, $time);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  logic [7:0] exh_exp;

  initial begin : stimulus
    rst = 1'b0; L = 1'b0; r_in = 1'b0; q_in = 1'b0;
    #1 rst = 1'b1;
    expect_q("reset_init", 1'b0, 1'b1);

    // Clocks ignored during reset
    @(posedge clk);
    expect_q("reset_clk_ignored", 1'b0, 1'b1);

    // Release reset and load Q=1
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "set_q1");

    // Mid-cycle async reset with clk low
    @(negedge clk);
    #2 rst = 1'b1;
    #1 expect_q("async_reset_now", 1'b0, 1'b1);
    L = 1'b1; r_in = 1'b1;
    @(posedge clk);
    expect_q("reset_edge1", 1'b0, 1'b1);
    @(posedge clk);
    expect_q("reset_edge2", 1'b0, 1'b1);

    // Reset released coincident with an edge: that edge is ignored
    @(posedge clk);
    rst <= 1'b0;
    expect_q("rst_release_edge", 1'b0, 1'b1);
    @(posedge clk);
    expect_q("rst_release_next", 1'b1, 1'b1);

    // Select q_in / r_in
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "sel_q_0");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "sel_q_1");
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "sel_r_0");
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "sel_r_1");

    // No edge, no change: inputs flip while clk high, then across the falling edge
    @(posedge clk);
    #1 L = 1'b1; r_in = 1'b0; q_in = 1'b1;
    expect_q("hold_clk_high", 1'b1, 1'b1);
    @(negedge clk);
    #1 expect_q("hold_falling", 1'b1, 1'b1);
    @(posedge clk);
    expect_q("hold_next_edge", 1'b0, 1'b0);

    // Same-timestep sampling: r_in changes with NBA at the edge
    @(negedge clk);
    L = 1'b1; r_in = 1'b0; q_in = 1'b0;
    @(posedge clk);
    r_in <= 1'b1;
    expect_q("nba_pre_edge", 1'b0, 1'b0);
    @(posedge clk);
    expect_q("nba_next_edge", 1'b1, 1'b1);

    // Exhaustive {L, r_in, q_in}; bit i holds the hand-computed next Q
    exh_exp = 8'b1100_1010;
    for (int unsigned i = 0; i < 8; i++) begin
      cycle(i[2], i[1], i[0], exh_exp[i], $sformatf("exh_%0d", i));
    end

    // Drain the scoreboard with a bounded wait
    for (int unsigned k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    #5;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dff8a.md
DFF8A -- requirements
Module: dff8a

Interface
REQ-001 Parameter RESET_VALUE, default 1'b0: value loaded into Q while reset is asserted.
REQ-002 clk  input  1  clock; Q updates only on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 L  input  1  load select; 1 selects r_in as next state, 0 selects q_in.
REQ-005 r_in  input  1  load data, captured when L=1.
REQ-006 q_in  input  1  recirculate/shift data, captured when L=0.
REQ-007 Q  output  1  registered flop output.
REQ-008 The block SHALL have one clock (clk) and reset SHALL be asynchronous and active-high (rst).

Function
REQ-009 The block SHALL implement a 2:1 mux feeding a single D flip-flop.
- next = L ? r_in : q_in.
REQ-010 On each rising edge of clk with rst=0, Q SHALL take the value of next sampled at that edge.
REQ-011 Latency SHALL be one clock edge from input sample to Q.
REQ-012 Q SHALL hold its value between rising edges.
- Changes on L, r_in or q_in while clk is high, low or falling SHALL NOT affect Q.
REQ-013 Q SHALL NOT depend combinationally on any input except rst.
- No path from L, r_in or q_in to Q.
REQ-014 L, r_in and q_in changing in the same timestep as the clock edge SHALL be sampled at their pre-edge values.
- This holds when stimulus uses nonblocking assignment.
REQ-015 Q SHALL never be X after the first reset or first clock edge, provided the inputs are known.
REQ-016 The flop SHALL NOT have an enable or hold mode other than through q_in.
- Hold is achieved externally by driving q_in=Q with L=0.

Reset
REQ-017 While rst=1, Q SHALL equal RESET_VALUE (default 0), independent of clk.
REQ-018 Asserting rst SHALL force Q to RESET_VALUE immediately (asynchronously).
- This applies even in the middle of a clock period.
REQ-019 While rst=1, rising edges of clk SHALL be ignored.
REQ-020 After rst deasserts, the first rising edge of clk SHALL load next per REQ-010.
REQ-021 If rst deasserts coincident with a rising edge, that edge SHALL be ignored.
- Q stays at RESET_VALUE until the following edge.

Verification
REQ-022 Reset: set Q=1, then raise rst=1 mid-cycle with clk low.
- Required: Q=0 immediately.
- Required: Q stays 0 across 2 rising edges with L=1, r_in=1.
REQ-023 Select q_in: rst=0, L=0, r_in=1, q_in=0, then rising edge.
- Required: Q=0.
- Then L=0, q_in=1, rising edge -> Q=1.
REQ-024 Select r_in: L=1, r_in=0, q_in=1, rising edge -> Q=0.
- Then L=1, r_in=1, q_in=0, rising edge -> Q=1.
REQ-025 No edge, no change: hold clk=1, change L=1, r_in=0, q_in=1.
- Required: Q unchanged until the next rising edge.
- Falling edge: Q unchanged.
REQ-026 Same-timestep sampling: with L=1, r_in=0, drive r_in<=1 nonblocking at the rising edge.
- Required: Q=0 after that edge.
- Required: Q=1 after the next edge.
REQ-027 Exhaustive: all 8 combinations of {L, r_in, q_in}, each followed by a rising edge.
- Required: Q matches L ? r_in : q_in every cycle.
